// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for instruction fetch and data access; data wins by default.
// Define ARB_IFETCH_FAIR_EN to hand the next grant to fetch after every data completion.
module mem_arbiter (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        iwait,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dwait,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ram_ready
);

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] IBUSY = 2'b01;
   localparam logic [1:0] DBUSY = 2'b10;

   logic [1:0]  state_r;
   logic [1:0]  state_next_s;
   logic        ram_ren_r;
   logic        ram_wen_r;
   logic [31:0] ram_addr_r;
   logic [31:0] ram_store_r;
   logic [31:0] iload_r;
   logic [31:0] dload_r;

   logic        d_req_s;
   logic        i_done_s;
   logic        d_done_s;
   logic        i_abort_s;
   logic        select_s;
   logic        fetch_ok_s;
   logic        prefer_i_s;
   logic        grant_i_s;
   logic        grant_d_s;

   // Decode requests, completions and whether a new grant may be chosen this edge
   always_comb begin
      d_req_s    = dREN | dWEN;
      i_done_s   = (state_r == IBUSY) & ram_ready;
      d_done_s   = (state_r == DBUSY) & ram_ready;
      i_abort_s  = (state_r == IBUSY) & ~ram_ready & ~iREN;
      select_s   = (state_r == IDLE) | i_done_s | d_done_s;
      // A fetch that just completed is still asserting iREN; it must not win again
      fetch_ok_s = iREN & ~i_done_s;
   end

`ifdef ARB_IFETCH_FAIR_EN
   logic fair_r;

   // Fetch is owed the next grant once a data access completes
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         fair_r <= 1'b0;
      end else if (grant_i_s || grant_d_s) begin
         fair_r <= 1'b0;
      end else if (d_done_s) begin
         fair_r <= 1'b1;
      end else begin
         fair_r <= fair_r;
      end
   end

   assign prefer_i_s = fair_r | d_done_s;
`else
   assign prefer_i_s = 1'b0;
`endif

   // Grant selection: data first unless fetch is owed a slot
   always_comb begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
      if (!select_s) begin
         grant_i_s = 1'b0;
         grant_d_s = 1'b0;
      end else if (prefer_i_s && fetch_ok_s) begin
         grant_i_s = 1'b1;
      end else if (d_req_s) begin
         grant_d_s = 1'b1;
      end else if (fetch_ok_s) begin
         grant_i_s = 1'b1;
      end else begin
         grant_i_s = 1'b0;
         grant_d_s = 1'b0;
      end
   end

   // Next-state: new grant, fall back to IDLE on completion/abort, else hold
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE, IBUSY, DBUSY: begin
            if (grant_d_s) begin
               state_next_s = DBUSY;
            end else if (grant_i_s) begin
               state_next_s = IBUSY;
            end else if (select_s || i_abort_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = state_r;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State register and RAM-side strobes, latched only at grant time
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r     <= IDLE;
         ram_ren_r   <= 1'b0;
         ram_wen_r   <= 1'b0;
         ram_addr_r  <= 32'h0000_0000;
         ram_store_r <= 32'h0000_0000;
      end else begin
         state_r <= state_next_s;
         if (grant_d_s) begin
            // Simultaneous dREN and dWEN is a write
            ram_ren_r   <= dREN & ~dWEN;
            ram_wen_r   <= dWEN;
            ram_addr_r  <= daddr;
            ram_store_r <= dstore;
         end else if (grant_i_s) begin
            ram_ren_r   <= 1'b1;
            ram_wen_r   <= 1'b0;
            ram_addr_r  <= iaddr;
            ram_store_r <= ram_store_r;
         end else if (state_next_s == IDLE) begin
            ram_ren_r   <= 1'b0;
            ram_wen_r   <= 1'b0;
            ram_addr_r  <= ram_addr_r;
            ram_store_r <= ram_store_r;
         end else begin
            ram_ren_r   <= ram_ren_r;
            ram_wen_r   <= ram_wen_r;
            ram_addr_r  <= ram_addr_r;
            ram_store_r <= ram_store_r;
         end
      end
   end

   // Hold the most recently completed read data per requester
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         iload_r <= 32'h0000_0000;
         dload_r <= 32'h0000_0000;
      end else begin
         if (i_done_s) begin
            iload_r <= ramload;
         end else begin
            iload_r <= iload_r;
         end
         if (d_done_s) begin
            dload_r <= ramload;
         end else begin
            dload_r <= dload_r;
         end
      end
   end

   assign ramREN   = ram_ren_r;
   assign ramWEN   = ram_wen_r;
   assign ramaddr  = ram_addr_r;
   assign ramstore = ram_store_r;

   assign iwait = iREN & ~i_done_s;
   assign dwait = d_req_s & ~d_done_s;
   assign iload = i_done_s ? ramload : iload_r;
   assign dload = d_done_s ? ramload : dload_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand sequences for
// abort/priority/reset corners, then random traffic against a transaction-level model.
module tb_mem_arbiter;

   logic        CLK;
   logic        nRST;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        iwait;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [31:0] dload;
   logic        dwait;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic        ram_ready;

   int n_checks;
   int n_fail;

   mem_arbiter dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .iREN      (iREN),
      .iaddr     (iaddr),
      .iload     (iload),
      .iwait     (iwait),
      .dREN      (dREN),
      .dWEN      (dWEN),
      .daddr     (daddr),
      .dstore    (dstore),
      .dload     (dload),
      .dwait     (dwait),
      .ramREN    (ramREN),
      .ramWEN    (ramWEN),
      .ramaddr   (ramaddr),
      .ramstore  (ramstore),
      .ramload   (ramload),
      .ram_ready (ram_ready)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        iren;
      logic [31:0] ia;
      logic        dren;
      logic        dwen;
      logic [31:0] da;
      logic [31:0] ds;
      logic        rr;
      logic [31:0] rl;
      logic        e_ren;
      logic        e_wen;
      logic [31:0] e_addr;
      logic [31:0] e_store;
      logic        e_iwait;
      logic        e_dwait;
      logic [31:0] e_iload;
      logic [31:0] e_dload;
   } vec_t;

   vec_t tbl [15];

   // Transaction-level reference: who owns the RAM and what access was granted
   int          m_owner;   // 0 none, 1 fetch, 2 data
   logic        m_re;
   logic        m_we;
   logic        m_owed;
   logic [31:0] m_addr;
   logic [31:0] m_store;
   logic [31:0] m_iload;
   logic [31:0] m_dload;

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic adv();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_reset();
      m_owner = 0;
      m_re    = 1'b0;
      m_we    = 1'b0;
      m_owed  = 1'b0;
      m_addr  = 32'h0;
      m_store = 32'h0;
      m_iload = 32'h0;
      m_dload = 32'h0;
   endtask

   task automatic model_check();
      logic i_fin;
      logic d_fin;
      i_fin = (m_owner == 1) && ram_ready;
      d_fin = (m_owner == 2) && ram_ready;
      chk1 ("rnd_ramREN",   ramREN,   m_re);
      chk1 ("rnd_ramWEN",   ramWEN,   m_we);
      chk32("rnd_ramaddr",  ramaddr,  m_addr);
      chk32("rnd_ramstore", ramstore, m_store);
      chk1 ("rnd_iwait",    iwait,    iREN && !i_fin);
      chk1 ("rnd_dwait",    dwait,    (dREN || dWEN) && !d_fin);
      chk32("rnd_iload",    iload,    i_fin ? ramload : m_iload);
      chk32("rnd_dload",    dload,    d_fin ? ramload : m_dload);
   endtask

   task automatic model_edge();
      logic i_fin;
      logic d_fin;
      logic abort;
      logic want_i;
      logic want_d;
      logic fetch_first;
      int   pick;
      i_fin = (m_owner == 1) && ram_ready;
      d_fin = (m_owner == 2) && ram_ready;
      abort = (m_owner == 1) && !ram_ready && !iREN;
      if (i_fin) m_iload = ramload;
      if (d_fin) m_dload = ramload;
      if (m_owner == 0 || i_fin || d_fin) begin
         want_i      = iREN && !i_fin;
         want_d      = dREN || dWEN;
         fetch_first = 1'b0;
`ifdef ARB_IFETCH_FAIR_EN
         fetch_first = want_i && (m_owed || d_fin);
`endif
         pick = fetch_first ? 1 : (want_d ? 2 : (want_i ? 1 : 0));
`ifdef ARB_IFETCH_FAIR_EN
         if (pick != 0) m_owed = 1'b0;
         else if (d_fin) m_owed = 1'b1;
`endif
         if (pick == 2) begin
            m_owner = 2;
            m_re    = dREN && !dWEN;
            m_we    = dWEN;
            m_addr  = daddr;
            m_store = dstore;
         end else if (pick == 1) begin
            m_owner = 1;
            m_re    = 1'b1;
            m_we    = 1'b0;
            m_addr  = iaddr;
         end else begin
            m_owner = 0;
            m_re    = 1'b0;
            m_we    = 1'b0;
         end
      end else if (abort) begin
         m_owner = 0;
         m_re    = 1'b0;
         m_we    = 1'b0;
      end
   endtask

   initial begin
      logic i_done_seen;
      logic d_done_seen;
      int   kind;
      n_checks  = 0;
      n_fail    = 0;
      nRST      = 1'b0;
      iREN      = 1'b0;
      iaddr     = 32'h0;
      dREN      = 1'b0;
      dWEN      = 1'b0;
      daddr     = 32'h0;
      dstore    = 32'h0;
      ramload   = 32'h0;
      ram_ready = 1'b0;
      model_reset();

      //              iREN  iaddr     dREN  dWEN  daddr      dstore        rr    ramload        ren   wen   ramaddr    ramstore      iwait dwait iload          dload
      tbl[0]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h0,         32'h0};
      tbl[1]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,         1'b1, 1'b0, 32'h40,  32'h0,        1'b1, 1'b0, 32'h0,         32'h0};
      tbl[2]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,         1'b1, 1'b0, 32'h40,  32'h0,        1'b1, 1'b0, 32'h0,         32'h0};
      tbl[3]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h8C010004,  1'b1, 1'b0, 32'h40,  32'h0,        1'b0, 1'b0, 32'h8C010004,  32'h0};
      tbl[4]  = '{1'b0, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,         1'b0, 1'b0, 32'h40,  32'h0,        1'b0, 1'b0, 32'h8C010004,  32'h0};
      tbl[5]  = '{1'b1, 32'h44, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,         1'b0, 1'b0, 32'h40,  32'h0,        1'b1, 1'b1, 32'h8C010004,  32'h0};
      tbl[6]  = '{1'b1, 32'h44, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,         1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 1'b1, 32'h8C010004,  32'h0};
      tbl[7]  = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1, 32'hA5A5A5A5,  1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 32'h8C010004,  32'hA5A5A5A5};
      tbl[8]  = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,         1'b1, 1'b0, 32'h44,  32'hDEADBEEF, 1'b1, 1'b0, 32'h8C010004,  32'hA5A5A5A5};
      tbl[9]  = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1, 32'h12345678,  1'b1, 1'b0, 32'h44,  32'hDEADBEEF, 1'b0, 1'b0, 32'h12345678,  32'hA5A5A5A5};
      tbl[10] = '{1'b0, 32'h44, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,         1'b0, 1'b0, 32'h44,  32'hDEADBEEF, 1'b0, 1'b0, 32'h12345678,  32'hA5A5A5A5};
      tbl[11] = '{1'b0, 32'h44, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1, 32'hFFFFFFFF,  1'b0, 1'b0, 32'h44,  32'hDEADBEEF, 1'b0, 1'b0, 32'h12345678,  32'hA5A5A5A5};
      tbl[12] = '{1'b0, 32'h44, 1'b1, 1'b0, 32'h200, 32'hDEADBEEF, 1'b0, 32'h0,         1'b0, 1'b0, 32'h44,  32'hDEADBEEF, 1'b0, 1'b1, 32'h12345678,  32'hA5A5A5A5};
      tbl[13] = '{1'b0, 32'h44, 1'b0, 1'b0, 32'h200, 32'hDEADBEEF, 1'b1, 32'hCAFEF00D,  1'b1, 1'b0, 32'h200, 32'hDEADBEEF, 1'b0, 1'b0, 32'h12345678,  32'hCAFEF00D};
      tbl[14] = '{1'b0, 32'h44, 1'b0, 1'b0, 32'h200, 32'hDEADBEEF, 1'b0, 32'h0,         1'b0, 1'b0, 32'h200, 32'hDEADBEEF, 1'b0, 1'b0, 32'h12345678,  32'hCAFEF00D};

      // Reset values
      repeat (2) @(posedge CLK);
      #1;
      chk1 ("rst_ramREN",   ramREN,   1'b0);
      chk1 ("rst_ramWEN",   ramWEN,   1'b0);
      chk32("rst_ramaddr",  ramaddr,  32'h0);
      chk32("rst_ramstore", ramstore, 32'h0);
      chk32("rst_iload",    iload,    32'h0);
      chk32("rst_dload",    dload,    32'h0);
      nRST = 1'b1;

      // Directed table: single fetch, write+fetch collision, idle ram_ready, data read
      for (int i = 0; i < 15; i++) begin
         iREN = tbl[i].iren;  iaddr = tbl[i].ia;
         dREN = tbl[i].dren;  dWEN  = tbl[i].dwen;
         daddr = tbl[i].da;   dstore = tbl[i].ds;
         ram_ready = tbl[i].rr; ramload = tbl[i].rl;
         @(negedge CLK);
         chk1 ($sformatf("tbl%0d_ramREN", i),   ramREN,   tbl[i].e_ren);
         chk1 ($sformatf("tbl%0d_ramWEN", i),   ramWEN,   tbl[i].e_wen);
         chk32($sformatf("tbl%0d_ramaddr", i),  ramaddr,  tbl[i].e_addr);
         chk32($sformatf("tbl%0d_ramstore", i), ramstore, tbl[i].e_store);
         chk1 ($sformatf("tbl%0d_iwait", i),    iwait,    tbl[i].e_iwait);
         chk1 ($sformatf("tbl%0d_dwait", i),    dwait,    tbl[i].e_dwait);
         chk32($sformatf("tbl%0d_iload", i),    iload,    tbl[i].e_iload);
         chk32($sformatf("tbl%0d_dload", i),    dload,    tbl[i].e_dload);
         adv();
      end

      // Fetch abort: iREN drops while the RAM is still busy; late ram_ready ignored
      iREN = 1'b1; iaddr = 32'h80; ram_ready = 1'b0; ramload = 32'h0;
      @(negedge CLK); chk1("abort_c0_iwait", iwait, 1'b1); chk1("abort_c0_ren", ramREN, 1'b0);
      adv();
      @(negedge CLK); chk1("abort_c1_ren", ramREN, 1'b1); chk32("abort_c1_addr", ramaddr, 32'h80);
      adv();
      iREN = 1'b0;
      @(negedge CLK); chk1("abort_c2_iwait", iwait, 1'b0);
      adv();
      @(negedge CLK); chk1("abort_c3_ren", ramREN, 1'b0);
      adv();
      ram_ready = 1'b1; ramload = 32'h99999999;
      @(negedge CLK); chk1("abort_c4_ren", ramREN, 1'b0); chk32("abort_c4_iload", iload, 32'h12345678);
      adv();
      ram_ready = 1'b0; ramload = 32'h0;
      @(negedge CLK); chk32("abort_c5_iload", iload, 32'h12345678); chk32("abort_c5_addr", ramaddr, 32'h80);
      adv();

      // Both requesters held with an always-ready RAM
      dREN = 1'b1; daddr = 32'h300; iREN = 1'b1; iaddr = 32'h400; ram_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         @(negedge CLK);
         if (k == 0) begin
            chk1("hold_c0_ren", ramREN, 1'b0);
         end else begin
            chk1($sformatf("hold_c%0d_ren", k), ramREN, 1'b1);
`ifdef ARB_IFETCH_FAIR_EN
            chk32($sformatf("hold_c%0d_addr", k), ramaddr, (k % 2 == 1) ? 32'h300 : 32'h400);
`else
            chk32($sformatf("hold_c%0d_addr", k), ramaddr, 32'h300);
            chk1 ($sformatf("hold_c%0d_iwait", k), iwait, 1'b1);
`endif
         end
         adv();
      end
      dREN = 1'b0; iREN = 1'b0;
      adv();
      ram_ready = 1'b0;
      adv();

      // Reset in the middle of a data write
      dWEN = 1'b1; daddr = 32'h500; dstore = 32'h77;
      @(negedge CLK); chk1("rstw_c0_dwait", dwait, 1'b1);
      adv();
      @(negedge CLK); chk1("rstw_c1_wen", ramWEN, 1'b1); chk32("rstw_c1_addr", ramaddr, 32'h500);
      #2;
      nRST = 1'b0;
      #1;
      chk1 ("rstw_async_wen",  ramWEN, 1'b0);
      chk32("rstw_async_addr", ramaddr, 32'h0);
      chk32("rstw_async_dload", dload, 32'h0);
      @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      #1;
      chk1("rstw_idle_wen",   ramWEN, 1'b0);
      chk1("rstw_idle_dwait", dwait,  1'b1);
      @(negedge CLK);
      chk1 ("rstw_regrant_wen",   ramWEN,   1'b1);
      chk32("rstw_regrant_addr",  ramaddr,  32'h500);
      chk32("rstw_regrant_store", ramstore, 32'h77);
      chk32("rstw_regrant_dload", dload,    32'h0);
      ram_ready = 1'b1; ramload = 32'h13579BDF;
      #1;
      chk1 ("rstw_done_dwait", dwait, 1'b0);
      chk32("rstw_done_dload", dload, 32'h13579BDF);
      dWEN = 1'b0;
      adv();
      ram_ready = 1'b0;

      // Random traffic against the reference model
      nRST = 1'b0;
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      adv();
      nRST = 1'b1;
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge CLK);
         model_check();
         i_done_seen = iREN && (m_owner == 1) && ram_ready;
         d_done_seen = (dREN || dWEN) && (m_owner == 2) && ram_ready;
         @(posedge CLK);
         model_edge();
         #1;
         if ($urandom_range(0, 399) == 0) begin
            nRST = 1'b0;
            #1;
            nRST = 1'b1;
            model_reset();
         end
         if (iREN) begin
            if (i_done_seen) begin
               if ($urandom_range(0, 1) == 0) iaddr = $urandom;
               else iREN = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
               iREN = 1'b0;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            iREN  = 1'b1;
            iaddr = $urandom;
         end
         if ((dREN || dWEN) && !d_done_seen) begin
            dREN = dREN;
         end else if ((dREN || dWEN) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 2) == 0)) begin
            kind   = int'($urandom_range(0, 2));
            dREN   = (kind != 1);
            dWEN   = (kind != 0);
            daddr  = $urandom;
            dstore = $urandom;
         end else begin
            dREN = 1'b0;
            dWEN = 1'b0;
         end
         ram_ready = 1'($urandom_range(0, 1));
         ramload   = $urandom;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, rising edge.
REQ-002 SHALL have ports: nRST  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: iREN  in  1  instruction fetch request; iaddr  in  32  fetch word address; iload  out  32  fetch data; iwait  out  1  fetch not complete.
REQ-004 SHALL have ports: dREN  in  1  data read request; dWEN  in  1  data write request; daddr  in  32  data address; dstore  in  32  write data; dload  out  32  read data; dwait  out  1  data access not complete.
REQ-005 SHALL have ports: ramREN  out  1; ramWEN  out  1; ramaddr  out  32; ramstore  out  32; ramload  in  32; ram_ready  in  1  RAM completes the presented access this cycle.
REQ-006 SHALL have no parameters; one clock, async active-low reset is fixed.

Function
REQ-007 SHALL share one RAM port between fetch and data requesters using FSM states IDLE, IBUSY, DBUSY.
REQ-008 In IDLE, if dREN|dWEN, SHALL latch daddr/dstore/dWEN and go to DBUSY; else if iREN, latch iaddr and go to IBUSY; else stay in IDLE.
REQ-009 Default arbitration SHALL give data strict priority over fetch on simultaneous requests.
REQ-010 ramREN/ramWEN/ramaddr/ramstore SHALL be registered and driven only from the latched grant: in IBUSY ramREN=1, ramWEN=0; in DBUSY ramREN=latched dREN&!dWEN, ramWEN=latched dWEN; in IDLE both are 0 and addr/store hold their last value.
REQ-011 Asserting dREN and dWEN together SHALL be treated as a write.
REQ-012 iwait SHALL be iREN & !(state==IBUSY & ram_ready); dwait SHALL be (dREN|dWEN) & !(state==DBUSY & ram_ready); both are combinational.
REQ-013 iload/dload SHALL pass ramload through in the completing cycle, and SHALL hold the last completed value in a register otherwise.
REQ-014 On completion (ram_ready in IBUSY/DBUSY), SHALL apply the REQ-008 selection in the same edge, allowing back-to-back grants with no idle cycle; the completed requester is excluded for that one selection.
REQ-015 Minimum latency SHALL be 2 cycles: request seen at edge t, strobes valid after t+1, wait low in that cycle if ram_ready=1.
REQ-016 Fetch abort: if iREN drops while IBUSY and ram_ready=0, SHALL return to IDLE next edge and drop ramREN; a late ram_ready is ignored.
REQ-017 Data accesses SHALL NOT be abortable; DBUSY persists until ram_ready regardless of dREN/dWEN.
REQ-018 Requesters SHALL hold address and data stable while their wait is high; latched values are never updated mid-access.
REQ-019 ram_ready in IDLE SHALL be ignored.

Reset
REQ-020 On nRST low, state SHALL be IDLE, ramREN=ramWEN=0, ramaddr=ramstore=0, held iload=dload=0, fairness flag=0, asynchronously.
REQ-021 Reset mid-access SHALL drop the access with no completion indicated; the RAM strobes fall immediately.

Configuration
REQ-022 With ARB_IFETCH_FAIR_EN defined, after a data completion with iREN high, fetch SHALL be granted next even if data also requests; data then follows fetch.
REQ-023 Without ARB_IFETCH_FAIR_EN, strict data priority (REQ-009) SHALL hold at every selection, and no fairness flag is implemented.

Verification
REQ-024 Sequence: iREN=1, iaddr=0x0040, RAM ready after 3 cycles, ramload=0x8C010004 -> ramREN=1 with ramaddr=0x0040; iwait low in cycle 4 with iload=0x8C010004; state returns to IDLE.
REQ-025 Sequence: iREN and dWEN rise together, daddr=0x0100, dstore=0xDEADBEEF -> first access is a RAM write of 0xDEADBEEF to 0x0100 with iwait high; fetch is granted on the completion edge; there are no gap cycles.
REQ-026 Sequence: fetch in IBUSY, iREN dropped at cycle 2, ram_ready pulses at cycle 4 -> IDLE at cycle 3, ramREN=0, iload unchanged, no grant.
REQ-027 Sequence: dREN held and iREN held continuously -> without the macro, the fetch is never granted; with ARB_IFETCH_FAIR_EN, grants alternate D, I, D, I.
REQ-028 Sequence: nRST asserted during DBUSY with ramWEN=1 -> ramWEN=0 immediately; after release, state is IDLE, dload=0, and a pending request is re-granted.
